rv32_decode_stage: RTL and testbench
====================================

// Module: rv32_decode_stage
// PURPOSE
//  Pipelined, parametrised RV32 decode stage between fetch and execute. Decodes one instruction
//  per cycle into mnemonic, rs1, rs2, rd, imm and pc.
//  Output side is a registered 2-entry elastic buffer with a valid/ready handshake.
//  Adds strict illegal-instruction detection, an optional M extension, flush, and an illegal counter.
// PARAMETERS
//  EN_M_EXT   1   1: decode MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU; 0: those encodings are illegal
//  PC_WIDTH   32  width of in_pc/out_pc
//  CNT_WIDTH  16  width of illegal_count (saturating)
// PORTS
//  clk           in   1          clock, all state on rising edge
//  rst           in   1          synchronous reset, active-high
//  flush         in   1          discard all buffered entries (pipeline redirect)
//  in_valid      in   1          fetch presents an instruction
//  in_ready      out  1          stage can accept this cycle
//  in_instr      in   32         raw instruction bits
//  in_pc         in   PC_WIDTH   pc of in_instr
//  out_valid     out  1          decoded entry available
//  out_ready     in   1          execute consumes this cycle
//  out_mnemonic  out  enum       fe_pkg mnemonic; NULL when illegal
//  out_rs1/rs2   out  5 each     source regs; 0 when the format has none
//  out_rd        out  5          dest reg; 0 when the format has none
//  out_imm       out  32         sign/zero-extended immediate per format; 0 for R-type
//  out_pc        out  PC_WIDTH   pc of the decoded entry
//  out_illegal   out  1          entry is an illegal encoding
//  illegal_count out  CNT_WIDTH  number of illegal entries consumed
// BEHAVIOUR
//  - Decode is combinational on in_instr. Decoded fields, not raw bits, are written into the buffer.
//    All out_* come straight from buffer registers.
//  - FSM states EMPTY/ONE/TWO = buffer occupancy. Define acc = in_valid&in_ready, pop = out_valid&out_ready.
//    EMPTY: acc -> ONE. ONE: acc&!pop -> TWO; !acc&pop -> EMPTY; otherwise stay.
//    TWO: pop -> ONE (acc impossible).
//  - in_ready = (state!=TWO) && !rst. out_valid = (state!=EMPTY).
//  - Latency: accepted in cycle N -> out_valid in N+1. Sustains 1 instr/cycle when out_ready is held high.
//  - Order is strictly FIFO. Output fields hold stable while out_valid && !out_ready.
//  - flush: next state EMPTY. It overrides acc and pop in the same cycle (the flushed input is dropped).
//    A pop in a flush cycle does not count toward illegal_count. illegal_count itself is not cleared.
//  - rst: state EMPTY, out_valid=0, all out_* fields=0, out_mnemonic=NULL, out_illegal=0, illegal_count=0.
//    Reset mid-transfer drops every buffered entry.
//  - illegal_count += 1 on pop && out_illegal && !flush, saturating at all-ones.
//  - Illegal (mnemonic NULL, rs1/rs2/rd/imm=0, out_illegal=1) when any of:
//    - opcode is not one of the 11 RV32I major opcodes;
//    - R-type funct7 is not 0x00, or 0x20 only with ADD/SUB and SRL/SRA funct3, or 0x01 only with EN_M_EXT=1;
//    - SLLI funct7 != 0x00, or SRLI/SRAI funct7 is not 0x00/0x20;
//    - load funct3 is 3, 6 or 7; store funct3 > 2; branch funct3 is 2 or 3; JALR funct3 != 0;
//    - system instr is not exactly 0x00000073 (ECALL) or 0x00100073 (EBREAK).
//  - Immediates per format: I sign-ext [31:20]; S {[31:25],[11:7]}; B and J with bit0=0; U {[31:12],12'b0}.
//    SLLI/SRLI/SRAI imm = zero-ext shamt [24:20].
// STRUCTURE
//  - fe_pkg: extend the mnemonic enum with MUL..REMU, and add opcode constants and FUNCT7_BASE/ALT/MULDIV.
//  - Sub-module rv32_decode_comb: pure combinational decode (instr -> fields + illegal), parametrised by EN_M_EXT.
//  - Top level holds the 2-entry buffer, the FSM and the counter.
// TESTING
//  1. Reset then out_ready=1; stream 0x00500093, 0x002081B3 -> ADDI rd1 rs1=0 imm=5, then ADD rd3 rs1=1 rs2=2;
//     each appears 1 cycle after accept.
//  2. 0x402081B3 -> SUB. 0x022081B3 -> MUL with EN_M_EXT=1, but illegal/NULL with EN_M_EXT=0.
//     0x202081B3 -> illegal.
//  3. out_ready=0, feed 3 instrs -> in_ready drops after 2 accepts. Release -> outputs in order, none lost or duplicated.
//  4. Buffer TWO, then flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed input absent.
//  5. 0xFFFFFFFF, 0x00200073, 0x00100073 popped -> illegal, illegal, EBREAK; illegal_count=2.
//     Preload CNT_WIDTH=2 near max -> count saturates at 3.
//  6. Assert rst while state TWO -> next cycle out_valid=0, illegal_count=0; in_ready stays 0 while rst=1.

Source files
------------

// File: rtl/fe_pkg.sv
// Shared decode types: mnemonics, instruction formats, opcode/funct7 constants,
// buffer occupancy states and the decoded-entry record.
package fe_pkg;

    typedef enum logic [5:0] {
        NULL,
        LUI, AUIPC, JAL, JALR,
        BEQ, BNE, BLT, BGE, BLTU, BGEU,
        LB, LH, LW, LBU, LHU,
        SB, SH, SW,
        ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
        ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
        FENCE, ECALL, EBREAK,
        MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
    } mnemonic_t;

    typedef enum logic [2:0] {
        FMT_NONE, FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J
    } fmt_t;

    typedef enum logic [1:0] {
        ST_EMPTY, ST_ONE, ST_TWO
    } occ_t;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [6:0] FUNCT7_BASE   = 7'h00;
    localparam logic [6:0] FUNCT7_ALT    = 7'h20;
    localparam logic [6:0] FUNCT7_MULDIV = 7'h01;

    localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

    typedef struct packed {
        mnemonic_t   mnemonic;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        illegal;
    } dec_t;

    localparam dec_t DEC_NULL = '{mnemonic: NULL, rs1: 5'd0, rs2: 5'd0, rd: 5'd0,
                                  imm: 32'd0, illegal: 1'b0};

endpackage

// File: rtl/rv32_decode_comb.sv
// Pure combinational RV32I(+M) decoder: raw instruction -> mnemonic, operands,
// immediate and a strict illegal flag. Illegal encodings yield all-zero fields.
module rv32_decode_comb
    import fe_pkg::*;
#(
    parameter int EN_M_EXT = 1
) (
    input  logic [31:0] instr,
    output dec_t        dec
);

    logic [6:0]  opcode_s;
    logic [2:0]  funct3_s;
    logic [6:0]  funct7_s;
    logic [31:0] imm_i_s, imm_s_s, imm_b_s, imm_u_s, imm_j_s, imm_sh_s;
    mnemonic_t   mn_s;
    fmt_t        fmt_s;
    logic        ill_s;

    assign opcode_s = instr[6:0];
    assign funct3_s = instr[14:12];
    assign funct7_s = instr[31:25];

    assign imm_i_s  = {{20{instr[31]}}, instr[31:20]};
    assign imm_s_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b_s  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u_s  = {instr[31:12], 12'h000};
    assign imm_j_s  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign imm_sh_s = {27'd0, instr[24:20]};

    // Classify the instruction: mnemonic, operand format and legality.
    always_comb begin
        mn_s  = NULL;
        fmt_s = FMT_NONE;
        ill_s = 1'b0;
        case (opcode_s)
            OPC_LUI:      begin mn_s = LUI;   fmt_s = FMT_U; end
            OPC_AUIPC:    begin mn_s = AUIPC; fmt_s = FMT_U; end
            OPC_JAL:      begin mn_s = JAL;   fmt_s = FMT_J; end
            OPC_JALR: begin
                fmt_s = FMT_I;
                if (funct3_s == 3'd0) mn_s = JALR;
                else                  ill_s = 1'b1;
            end
            OPC_BRANCH: begin
                fmt_s = FMT_B;
                case (funct3_s)
                    3'd0:    mn_s = BEQ;
                    3'd1:    mn_s = BNE;
                    3'd4:    mn_s = BLT;
                    3'd5:    mn_s = BGE;
                    3'd6:    mn_s = BLTU;
                    3'd7:    mn_s = BGEU;
                    default: ill_s = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                fmt_s = FMT_I;
                case (funct3_s)
                    3'd0:    mn_s = LB;
                    3'd1:    mn_s = LH;
                    3'd2:    mn_s = LW;
                    3'd4:    mn_s = LBU;
                    3'd5:    mn_s = LHU;
                    default: ill_s = 1'b1;
                endcase
            end
            OPC_STORE: begin
                fmt_s = FMT_S;
                case (funct3_s)
                    3'd0:    mn_s = SB;
                    3'd1:    mn_s = SH;
                    3'd2:    mn_s = SW;
                    default: ill_s = 1'b1;
                endcase
            end
            OPC_OP_IMM: begin
                fmt_s = FMT_I;
                case (funct3_s)
                    3'd0: mn_s = ADDI;
                    3'd2: mn_s = SLTI;
                    3'd3: mn_s = SLTIU;
                    3'd4: mn_s = XORI;
                    3'd6: mn_s = ORI;
                    3'd7: mn_s = ANDI;
                    3'd1: begin
                        fmt_s = FMT_SH;
                        if (funct7_s == FUNCT7_BASE) mn_s = SLLI;
                        else                         ill_s = 1'b1;
                    end
                    3'd5: begin
                        fmt_s = FMT_SH;
                        if (funct7_s == FUNCT7_BASE)     mn_s = SRLI;
                        else if (funct7_s == FUNCT7_ALT) mn_s = SRAI;
                        else                             ill_s = 1'b1;
                    end
                    default: ill_s = 1'b1;
                endcase
            end
            OPC_OP: begin
                fmt_s = FMT_R;
                case (funct7_s)
                    FUNCT7_BASE: begin
                        case (funct3_s)
                            3'd0:    mn_s = ADD;
                            3'd1:    mn_s = SLL;
                            3'd2:    mn_s = SLT;
                            3'd3:    mn_s = SLTU;
                            3'd4:    mn_s = XOR;
                            3'd5:    mn_s = SRL;
                            3'd6:    mn_s = OR;
                            default: mn_s = AND;
                        endcase
                    end
                    FUNCT7_ALT: begin
                        if (funct3_s == 3'd0)      mn_s = SUB;
                        else if (funct3_s == 3'd5) mn_s = SRA;
                        else                       ill_s = 1'b1;
                    end
                    FUNCT7_MULDIV: begin
                        if (EN_M_EXT != 0) begin
                            case (funct3_s)
                                3'd0:    mn_s = MUL;
                                3'd1:    mn_s = MULH;
                                3'd2:    mn_s = MULHSU;
                                3'd3:    mn_s = MULHU;
                                3'd4:    mn_s = DIV;
                                3'd5:    mn_s = DIVU;
                                3'd6:    mn_s = REM;
                                default: mn_s = REMU;
                            endcase
                        end else begin
                            ill_s = 1'b1;
                        end
                    end
                    default: ill_s = 1'b1;
                endcase
            end
            OPC_MISC_MEM: begin mn_s = FENCE; fmt_s = FMT_I; end
            OPC_SYSTEM: begin
                if (instr == INSTR_ECALL)       mn_s = ECALL;
                else if (instr == INSTR_EBREAK) mn_s = EBREAK;
                else                            ill_s = 1'b1;
            end
            default: ill_s = 1'b1;
        endcase
    end

    // Populate operand fields by format; illegal encodings collapse to zeros.
    always_comb begin
        dec         = DEC_NULL;
        dec.illegal = ill_s;
        if (ill_s) begin
            dec.mnemonic = NULL;
        end else begin
            dec.mnemonic = mn_s;
            case (fmt_s)
                FMT_R:  begin dec.rs1 = instr[19:15]; dec.rs2 = instr[24:20]; dec.rd = instr[11:7]; end
                FMT_I:  begin dec.rs1 = instr[19:15]; dec.rd = instr[11:7]; dec.imm = imm_i_s; end
                FMT_SH: begin dec.rs1 = instr[19:15]; dec.rd = instr[11:7]; dec.imm = imm_sh_s; end
                FMT_S:  begin dec.rs1 = instr[19:15]; dec.rs2 = instr[24:20]; dec.imm = imm_s_s; end
                FMT_B:  begin dec.rs1 = instr[19:15]; dec.rs2 = instr[24:20]; dec.imm = imm_b_s; end
                FMT_U:  begin dec.rd = instr[11:7]; dec.imm = imm_u_s; end
                FMT_J:  begin dec.rd = instr[11:7]; dec.imm = imm_j_s; end
                default: dec.imm = 32'd0;
            endcase
        end
    end

endmodule

// File: rtl/rv32_decode_stage.sv
// RV32 decode stage: combinational decode feeding a registered 2-entry elastic
// buffer (head drives the outputs directly), plus a saturating illegal counter.
module rv32_decode_stage
    import fe_pkg::*;
#(
    parameter int EN_M_EXT  = 1,
    parameter int PC_WIDTH  = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_instr,
    input  logic [PC_WIDTH-1:0]  in_pc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output mnemonic_t            out_mnemonic,
    output logic [4:0]           out_rs1,
    output logic [4:0]           out_rs2,
    output logic [4:0]           out_rd,
    output logic [31:0]          out_imm,
    output logic [PC_WIDTH-1:0]  out_pc,
    output logic                 out_illegal,
    output logic [CNT_WIDTH-1:0] illegal_count
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    occ_t                 state_r;
    dec_t                 head_r, tail_r;
    logic [PC_WIDTH-1:0]  head_pc_r, tail_pc_r;
    logic [CNT_WIDTH-1:0] count_r;
    dec_t                 dec_s;
    logic                 acc_s, pop_s;

    rv32_decode_comb #(.EN_M_EXT(EN_M_EXT)) u_decode (
        .instr (in_instr),
        .dec   (dec_s)
    );

    assign in_ready  = (state_r != ST_TWO) && !rst;
    assign out_valid = (state_r != ST_EMPTY);
    assign acc_s     = in_valid && in_ready;
    assign pop_s     = out_valid && out_ready;

    assign out_mnemonic  = head_r.mnemonic;
    assign out_rs1       = head_r.rs1;
    assign out_rs2       = head_r.rs2;
    assign out_rd        = head_r.rd;
    assign out_imm       = head_r.imm;
    assign out_illegal   = head_r.illegal;
    assign out_pc        = head_pc_r;
    assign illegal_count = count_r;

    // Occupancy FSM and buffer entries; flush empties the buffer and drops any accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_EMPTY;
            head_r    <= DEC_NULL;
            tail_r    <= DEC_NULL;
            head_pc_r <= '0;
            tail_pc_r <= '0;
        end else if (flush) begin
            state_r <= ST_EMPTY;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (acc_s) begin
                        head_r    <= dec_s;
                        head_pc_r <= in_pc;
                        state_r   <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (acc_s && pop_s) begin
                        head_r    <= dec_s;
                        head_pc_r <= in_pc;
                    end else if (acc_s) begin
                        tail_r    <= dec_s;
                        tail_pc_r <= in_pc;
                        state_r   <= ST_TWO;
                    end else if (pop_s) begin
                        state_r <= ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (pop_s) begin
                        head_r    <= tail_r;
                        head_pc_r <= tail_pc_r;
                        state_r   <= ST_ONE;
                    end
                end
                default: state_r <= ST_EMPTY;
            endcase
        end
    end

    // Saturating count of illegal entries handed to execute (not during flush).
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= '0;
        end else if (pop_s && head_r.illegal && !flush && (count_r != CNT_MAX)) begin
            count_r <= count_r + CNT_ONE;
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: tb/tb_rv32_decode_stage.sv
// Directed self-checking bench for rv32_decode_stage. Two instances share the
// inputs: the default configuration and one without M extension and a 2-bit counter.
module tb_rv32_decode_stage;
    import fe_pkg::*;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_instr, in_pc;

    logic        in_ready, out_valid, out_illegal;
    mnemonic_t   out_mnemonic;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic [31:0] out_imm, out_pc;
    logic [15:0] illegal_count;

    logic        in_ready_nm, out_valid_nm, out_illegal_nm;
    mnemonic_t   out_mnemonic_nm;
    logic [4:0]  out_rs1_nm, out_rs2_nm, out_rd_nm;
    logic [31:0] out_imm_nm, out_pc_nm;
    logic [1:0]  illegal_count_nm;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;
    int exp_cnt_nm = 0;

    always #5 clk = ~clk;

    rv32_decode_stage #(.EN_M_EXT(1), .PC_WIDTH(32), .CNT_WIDTH(16)) u_dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_mnemonic(out_mnemonic), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_imm(out_imm), .out_pc(out_pc), .out_illegal(out_illegal),
        .illegal_count(illegal_count)
    );

    rv32_decode_stage #(.EN_M_EXT(0), .PC_WIDTH(32), .CNT_WIDTH(2)) u_dut_nm (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_nm),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid_nm), .out_ready(out_ready),
        .out_mnemonic(out_mnemonic_nm), .out_rs1(out_rs1_nm), .out_rs2(out_rs2_nm),
        .out_rd(out_rd_nm), .out_imm(out_imm_nm), .out_pc(out_pc_nm),
        .out_illegal(out_illegal_nm), .illegal_count(illegal_count_nm)
    );

    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        in_instr = 32'h0050_0093; in_pc = 32'h0;
        step(); step();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %0b want 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        checks++; if (out_mnemonic !== NULL) begin errors++; $display("FAIL reset_mnemonic got %0d want %0d", out_mnemonic, NULL); end
        checks++; if ({out_rs1, out_rs2, out_rd, out_imm, out_pc, out_illegal} !== 80'd0) begin errors++; $display("FAIL reset_fields got nonzero imm=%0h pc=%0h", out_imm, out_pc); end
        checks++; if (illegal_count !== 16'd0) begin errors++; $display("FAIL reset_count got %0d want 0", illegal_count); end
        rst = 1'b0; in_valid = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got %0b want 1", in_ready); end
    endtask

    task automatic test_stream();
        logic [31:0] ins [6];
        mnemonic_t   mn  [6];
        logic [4:0]  rd [6], rs1 [6], rs2 [6];
        logic [31:0] imm [6];
        ins = '{32'h0050_0093, 32'h0020_81B3, 32'h0020_A423, 32'hFE20_8EE3, 32'h1234_52B7, 32'h4031_5093};
        mn  = '{ADDI, ADD, SW, BEQ, LUI, SRAI};
        rd  = '{5'd1, 5'd3, 5'd0, 5'd0, 5'd5, 5'd1};
        rs1 = '{5'd0, 5'd1, 5'd1, 5'd1, 5'd0, 5'd2};
        rs2 = '{5'd0, 5'd2, 5'd2, 5'd2, 5'd0, 5'd0};
        imm = '{32'd5, 32'd0, 32'd8, 32'hFFFF_FFFC, 32'h1234_5000, 32'd3};
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_instr = ins[i]; in_pc = 32'h100 + 32'(i * 4);
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready[%0d] got %0b want 1", i, in_ready); end
            step();
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d] got %0b want 1", i, out_valid); end
            checks++; if (out_mnemonic !== mn[i] || out_mnemonic_nm !== mn[i]) begin errors++; $display("FAIL stream_mnemonic[%0d] got %0d/%0d want %0d", i, out_mnemonic, out_mnemonic_nm, mn[i]); end
            checks++; if (out_rd !== rd[i] || out_rs1 !== rs1[i] || out_rs2 !== rs2[i]) begin errors++; $display("FAIL stream_regs[%0d] got rd=%0d rs1=%0d rs2=%0d want rd=%0d rs1=%0d rs2=%0d", i, out_rd, out_rs1, out_rs2, rd[i], rs1[i], rs2[i]); end
            checks++; if (out_imm !== imm[i]) begin errors++; $display("FAIL stream_imm[%0d] got %0h want %0h", i, out_imm, imm[i]); end
            checks++; if (out_pc !== 32'h100 + 32'(i * 4) || out_pc_nm !== out_pc || out_illegal !== 1'b0) begin errors++; $display("FAIL stream_pc[%0d] got %0h ill=%0b want %0h ill=0", i, out_pc, out_illegal, 32'h100 + 32'(i * 4)); end
        end
        in_valid = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain got %0b want 0", out_valid); end
        checks++; if (illegal_count !== 16'(exp_cnt)) begin errors++; $display("FAIL stream_count got %0d want %0d", illegal_count, exp_cnt); end
    endtask

    task automatic test_mext();
        logic [31:0] ins [3];
        mnemonic_t   mn [3], mn_nm [3];
        logic        il [3], il_nm [3];
        ins   = '{32'h4020_81B3, 32'h0220_81B3, 32'h2020_81B3};
        mn    = '{SUB, MUL, NULL};
        mn_nm = '{SUB, NULL, NULL};
        il    = '{1'b0, 1'b0, 1'b1};
        il_nm = '{1'b0, 1'b1, 1'b1};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_instr = ins[i]; in_pc = 32'h200 + 32'(i * 4);
            step();
            checks++; if (out_mnemonic !== mn[i] || out_illegal !== il[i]) begin errors++; $display("FAIL mext_main[%0d] got %0d ill=%0b want %0d ill=%0b", i, out_mnemonic, out_illegal, mn[i], il[i]); end
            checks++; if (out_mnemonic_nm !== mn_nm[i] || out_illegal_nm !== il_nm[i]) begin errors++; $display("FAIL mext_nm[%0d] got %0d ill=%0b want %0d ill=%0b", i, out_mnemonic_nm, out_illegal_nm, mn_nm[i], il_nm[i]); end
            if (il_nm[i]) begin
                checks++; if ({out_rs1_nm, out_rs2_nm, out_rd_nm, out_imm_nm} !== 47'd0) begin errors++; $display("FAIL mext_nm_zero[%0d] got rs1=%0d rs2=%0d rd=%0d imm=%0h want 0", i, out_rs1_nm, out_rs2_nm, out_rd_nm, out_imm_nm); end
            end else begin
                checks++; if (out_rd_nm !== 5'd3 || out_rs1_nm !== 5'd1 || out_rs2_nm !== 5'd2) begin errors++; $display("FAIL mext_nm_regs[%0d] got rd=%0d rs1=%0d rs2=%0d want 3/1/2", i, out_rd_nm, out_rs1_nm, out_rs2_nm); end
            end
        end
        in_valid = 1'b0;
        step();
        exp_cnt += 1; exp_cnt_nm += 2;
        checks++; if (illegal_count !== 16'(exp_cnt)) begin errors++; $display("FAIL mext_count got %0d want %0d", illegal_count, exp_cnt); end
        checks++; if (illegal_count_nm !== 2'(exp_cnt_nm)) begin errors++; $display("FAIL mext_count_nm got %0d want %0d", illegal_count_nm, exp_cnt_nm); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h0010_0093; in_pc = 32'h300;
        step();
        in_instr = 32'h0020_0113; in_pc = 32'h304;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_one got %0b want 1", in_ready); end
        step();
        in_instr = 32'h0030_0193; in_pc = 32'h308;
        #1;
        checks++; if (in_ready !== 1'b0 || in_ready_nm !== 1'b0) begin errors++; $display("FAIL bp_ready_two got %0b/%0b want 0", in_ready, in_ready_nm); end
        step();
        checks++; if (out_rd !== 5'd1 || out_imm !== 32'd1 || out_pc !== 32'h300 || in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold got rd=%0d imm=%0h pc=%0h rdy=%0b want rd=1 imm=1 pc=300 rdy=0", out_rd, out_imm, out_pc, in_ready); end
        out_ready = 1'b1;
        step();
        checks++; if (out_valid !== 1'b1 || out_rd !== 5'd2 || out_imm !== 32'd2 || out_pc !== 32'h304) begin errors++; $display("FAIL bp_second got v=%0b rd=%0d imm=%0h pc=%0h want v=1 rd=2 imm=2 pc=304", out_valid, out_rd, out_imm, out_pc); end
        step();
        checks++; if (out_valid !== 1'b1 || out_rd !== 5'd3 || out_imm !== 32'd3 || out_pc !== 32'h308) begin errors++; $display("FAIL bp_third got v=%0b rd=%0d imm=%0h pc=%0h want v=1 rd=3 imm=3 pc=308", out_valid, out_rd, out_imm, out_pc); end
        in_valid = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got %0b want 0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h0010_0093; in_pc = 32'h400;
        step();
        in_instr = 32'h0020_0113; in_pc = 32'h404;
        step();
        flush = 1'b1; in_instr = 32'h0030_0193; in_pc = 32'h408;
        step();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_two got v=%0b rdy=%0b want v=0 rdy=1", out_valid, in_ready); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_absent got %0b want 0", out_valid); end
        in_valid = 1'b1; in_instr = 32'h0010_0093;
        step();
        flush = 1'b1; in_instr = 32'h0030_0193;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_one_ready got %0b want 1", in_ready); end
        step();
        flush = 1'b0; in_valid = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_one_drop got %0b want 0", out_valid); end
        out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'hFFFF_FFFF;
        step();
        in_valid = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;
        checks++; if (illegal_count !== 16'(exp_cnt) || out_valid !== 1'b0) begin errors++; $display("FAIL flush_pop_count got %0d v=%0b want %0d v=0", illegal_count, out_valid, exp_cnt); end
    endtask

    task automatic test_illegal();
        logic [31:0] ins [3];
        mnemonic_t   mn [3];
        logic        il [3];
        ins = '{32'hFFFF_FFFF, 32'h0020_0073, 32'h0010_0073};
        mn  = '{NULL, NULL, EBREAK};
        il  = '{1'b1, 1'b1, 1'b0};
        rst = 1'b1; step(); rst = 1'b0;
        exp_cnt = 0; exp_cnt_nm = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_instr = ins[i]; in_pc = 32'h500 + 32'(i * 4);
            step();
            checks++; if (out_mnemonic !== mn[i] || out_illegal !== il[i]) begin errors++; $display("FAIL illegal_kind[%0d] got %0d ill=%0b want %0d ill=%0b", i, out_mnemonic, out_illegal, mn[i], il[i]); end
            checks++; if ({out_rs1, out_rs2, out_rd, out_imm} !== 47'd0) begin errors++; $display("FAIL illegal_zero[%0d] got rs1=%0d rs2=%0d rd=%0d imm=%0h want 0", i, out_rs1, out_rs2, out_rd, out_imm); end
        end
        in_valid = 1'b0;
        step();
        exp_cnt = 2; exp_cnt_nm = 2;
        checks++; if (illegal_count !== 16'(exp_cnt) || illegal_count_nm !== 2'(exp_cnt_nm)) begin errors++; $display("FAIL illegal_count got %0d/%0d want %0d/%0d", illegal_count, illegal_count_nm, exp_cnt, exp_cnt_nm); end
    endtask

    task automatic test_saturate();
        out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'hFFFF_FFFF;
        step();
        step();
        exp_cnt = 3; exp_cnt_nm = 3;
        checks++; if (illegal_count !== 16'(exp_cnt) || illegal_count_nm !== 2'(exp_cnt_nm)) begin errors++; $display("FAIL sat_first got %0d/%0d want %0d/%0d", illegal_count, illegal_count_nm, exp_cnt, exp_cnt_nm); end
        in_valid = 1'b0;
        step();
        exp_cnt = 4;
        checks++; if (illegal_count !== 16'(exp_cnt) || illegal_count_nm !== 2'd3) begin errors++; $display("FAIL sat_hold got %0d/%0d want %0d/3", illegal_count, illegal_count_nm, exp_cnt); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h0010_0093;
        step();
        in_instr = 32'h0020_0113;
        step();
        checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL rstmid_full got v=%0b rdy=%0b want v=1 rdy=0", out_valid, in_ready); end
        rst = 1'b1;
        step();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL rstmid_state got v=%0b rdy=%0b want 0/0", out_valid, in_ready); end
        checks++; if (illegal_count !== 16'd0 || illegal_count_nm !== 2'd0) begin errors++; $display("FAIL rstmid_count got %0d/%0d want 0", illegal_count, illegal_count_nm); end
        checks++; if (out_mnemonic !== NULL || out_rd !== 5'd0 || out_imm !== 32'd0) begin errors++; $display("FAIL rstmid_fields got mn=%0d rd=%0d imm=%0h want NULL/0/0", out_mnemonic, out_rd, out_imm); end
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_after got v=%0b rdy=%0b want 0/1", out_valid, in_ready); end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = 32'd0; in_pc = 32'd0;
        @(negedge clk);
        test_reset();
        test_stream();
        test_mext();
        test_backpressure();
        test_flush();
        test_illegal();
        test_saturate();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
